// File: rtl/ahb_pkg.sv
// ============================================================================
//  Module   : ahb_pkg
//  Purpose  : AHB-Lite encodings shared between the address decoder and the
//             slave-to-master response mux (HTRANS, HRESP, select codes and
//             the default-slave state encoding).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Data-phase select codes produced by the decoder
  localparam int SEL_NONE       = 0;
  localparam int SEL_DEFAULT    = 1;
  localparam int SEL_SLAVE_BASE = 2;

  // Default-slave sequence: ERR1 is only ever seen on entry, ERR2 is held
  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  // NONSEQ and SEQ are the transfers that require a real response
  function automatic logic is_active_xfer(input htrans_e t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_default_slave.sv
// ============================================================================
//  Module   : ahb_default_slave
//  Purpose  : Default slave for unmapped addresses. Answers NONSEQ/SEQ with
//             a two-cycle ERROR and IDLE/BUSY with a zero-wait OKAY.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic    ahb_clk_in,
  input  logic    ahb_rstn_in,
  input  logic    i_active,
  input  htrans_e i_htrans_dp,
  output logic    o_hready,
  output logic    o_hresp
);

  ds_state_e r_state;
  ds_state_e w_state_cur;

  // ERR1 is recognised on entry so the very first data-phase cycle shows it
  always_comb begin
    w_state_cur = r_state;
    if ((r_state == DS_IDLE) && i_active && is_active_xfer(i_htrans_dp)) begin
      w_state_cur = DS_ERR1;
    end
  end

  // Sequence ERR1 -> ERR2 -> IDLE; leaves the sequence whenever deselected
  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      r_state <= DS_IDLE;
    end else if (!i_active) begin
      r_state <= DS_IDLE;
    end else begin
      case (w_state_cur)
        DS_ERR1: r_state <= DS_ERR2;
        default: r_state <= DS_IDLE;
      endcase
    end
  end

  // Response decode of the state currently presented to the master
  always_comb begin
    o_hready = 1'b1;
    o_hresp  = HRESP_OKAY;
    case (w_state_cur)
      DS_ERR1: begin
        o_hready = 1'b0;
        o_hresp  = HRESP_ERROR;
      end
      DS_ERR2: begin
        o_hready = 1'b1;
        o_hresp  = HRESP_ERROR;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ahb_slave_mux.sv
// ============================================================================
//  Module   : ahb_slave_mux
//  Purpose  : AHB-Lite slave-to-master response mux. Routes the selected
//             slave's HRDATA/HREADYOUT/HRESP to the master, embeds the
//             default slave, and returns HREADY to the decoder.
//             Optional hung-slave timeout: define AHB_MUX_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_slave_mux
  import ahb_pkg::*;
#(
  parameter int SLAVE_DEVICES  = 2,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                    ahb_clk_in,
  input  logic                                    ahb_rstn_in,
  input  logic [$clog2(SLAVE_DEVICES):0]          multi_sel_in,
  input  logic [1:0]                              htrans_in,
  input  logic [SLAVE_DEVICES*AHB_DATA_WIDTH-1:0] slave_rdata_in,
  input  logic [SLAVE_DEVICES-1:0]                slave_ready_in,
  input  logic [SLAVE_DEVICES-1:0]                slave_resp_in,
  output logic [AHB_DATA_WIDTH-1:0]               hrdata_out,
  output logic                                    hready_out,
  output logic                                    hresp_out,
  output logic                                    multi_ready_out,
  output logic                                    timeout_flag_out
);

  if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 1023)) begin : g_timeout_range_chk
    $error("ahb_slave_mux: TIMEOUT_CYCLES must be within 2..1023");
  end

  logic [31:0]               w_sel;
  logic                      w_slv_sel;
  logic                      w_def_sel;
  logic [AHB_DATA_WIDTH-1:0] w_slv_rdata;
  logic                      w_slv_ready;
  logic                      w_slv_resp;
  logic                      w_ds_hready;
  logic                      w_ds_hresp;
  logic                      w_to_err1;
  logic                      w_to_err2;
  logic [AHB_DATA_WIDTH-1:0] w_hrdata;
  logic                      w_hready;
  logic                      w_hresp;
  htrans_e                   r_htrans_dp;

  assign w_sel = 32'(multi_sel_in);

  // Pick the addressed real slave; codes outside the slave range fall to the default slave
  always_comb begin
    w_slv_sel   = 1'b0;
    w_slv_rdata = '0;
    w_slv_ready = 1'b1;
    w_slv_resp  = HRESP_OKAY;
    for (int k = 0; k < SLAVE_DEVICES; k++) begin
      if (w_sel == 32'(SEL_SLAVE_BASE + k)) begin
        w_slv_sel   = 1'b1;
        w_slv_rdata = slave_rdata_in[k*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
        w_slv_ready = slave_ready_in[k];
        w_slv_resp  = slave_resp_in[k];
      end
    end
  end

  assign w_def_sel = (w_sel != 32'(SEL_NONE)) && !w_slv_sel;

  // Track HTRANS into the data phase so it lines up with multi_sel_in
  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      r_htrans_dp <= HTRANS_IDLE;
    end else if (w_hready) begin
      r_htrans_dp <= htrans_e'(htrans_in);
    end
  end

  ahb_default_slave u_default_slave (
    .ahb_clk_in  (ahb_clk_in),
    .ahb_rstn_in (ahb_rstn_in),
    .i_active    (w_def_sel),
    .i_htrans_dp (r_htrans_dp),
    .o_hready    (w_ds_hready),
    .o_hresp     (w_ds_hresp)
  );

`ifdef AHB_MUX_TIMEOUT_EN
  localparam int c_CNT_W = 10;

  logic [c_CNT_W-1:0]            r_to_cnt;
  logic [c_CNT_W-1:0]            w_cnt_cur;
  logic [$clog2(SLAVE_DEVICES):0] r_sel_q;
  logic                          r_to_err2;
  logic                          r_flag;

  // A change of select starts a fresh wait count
  assign w_cnt_cur = (multi_sel_in == r_sel_q) ? r_to_cnt : '0;
  assign w_to_err2 = r_to_err2 && w_slv_sel;
  assign w_to_err1 = w_slv_sel && !w_to_err2 &&
                     (w_cnt_cur == c_CNT_W'(TIMEOUT_CYCLES - 1));

  // Count consecutive slave wait states and arm the forced two-cycle ERROR
  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      r_to_cnt  <= '0;
      r_sel_q   <= '0;
      r_to_err2 <= 1'b0;
      r_flag    <= 1'b0;
    end else begin
      r_sel_q   <= multi_sel_in;
      r_to_err2 <= w_to_err1;
      if (w_to_err1) begin
        r_flag <= 1'b1;
      end
      if (w_slv_sel && !w_slv_ready && !w_to_err1 && !w_to_err2) begin
        r_to_cnt <= w_cnt_cur + 1'b1;
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign timeout_flag_out = r_flag;
`else
  assign w_to_err1        = 1'b0;
  assign w_to_err2        = 1'b0;
  assign timeout_flag_out = 1'b0;
`endif

  // Final response: forced timeout ERROR overrides the slave, then slave, then default slave
  always_comb begin
    w_hrdata = '0;
    w_hready = 1'b1;
    w_hresp  = HRESP_OKAY;
    if (w_to_err1) begin
      w_hready = 1'b0;
      w_hresp  = HRESP_ERROR;
    end else if (w_to_err2) begin
      w_hready = 1'b1;
      w_hresp  = HRESP_ERROR;
    end else if (w_slv_sel) begin
      w_hrdata = w_slv_rdata;
      w_hready = w_slv_ready;
      w_hresp  = w_slv_resp;
    end else if (w_def_sel) begin
      w_hready = w_ds_hready;
      w_hresp  = w_ds_hresp;
    end
  end

  assign hrdata_out      = w_hrdata;
  assign hready_out      = w_hready;
  assign hresp_out       = w_hresp;
  assign multi_ready_out = w_hready;

endmodule

`default_nettype wire

// File: tb/tb_ahb_slave_mux.sv
// ============================================================================
//  Module   : tb_ahb_slave_mux
//  Purpose  : Self-checking bench for ahb_slave_mux: transfer-level reference
//             model compared every cycle, directed literal checks, and
//             randomized decoder/slave traffic.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_slave_mux;

  localparam int N = 2;
  localparam int W = 32;
  localparam int T = 16;

  logic           clk  = 1'b0;
  logic           rstn = 1'b0;
  logic [1:0]     sel;
  logic [1:0]     htrans;
  logic [N*W-1:0] rdata;
  logic [N-1:0]   ready;
  logic [N-1:0]   resp;
  logic [W-1:0]   hrdata;
  logic           hready;
  logic           hresp;
  logic           mready;
  logic           flag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ahb_slave_mux #(
    .SLAVE_DEVICES  (N),
    .AHB_DATA_WIDTH (W),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .ahb_clk_in       (clk),
    .ahb_rstn_in      (rstn),
    .multi_sel_in     (sel),
    .htrans_in        (htrans),
    .slave_rdata_in   (rdata),
    .slave_ready_in   (ready),
    .slave_resp_in    (resp),
    .hrdata_out       (hrdata),
    .hready_out       (hready),
    .hresp_out        (hresp),
    .multi_ready_out  (mready),
    .timeout_flag_out (flag)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state, at transfer granularity
  logic [1:0] m_dp      = 2'd0;  // HTRANS of the transfer currently in data phase
  bit         m_def_err = 1'b0;  // default slave already gave the first ERROR cycle
  int         m_wait    = 0;     // wait states already spent on the current slave transfer
  bit         m_to2     = 1'b0;  // forced timeout ERROR, second cycle pending
  bit         m_flag    = 1'b0;

  logic [W-1:0] e_rdata;
  logic         e_ready = 1'b1;
  logic         e_resp;
  bit           e_to1, e_def1, e_slv;

  // Compare process: expected response from the model, checked every cycle
  always @(negedge clk) begin
    int s;
    s       = int'(sel);
    e_rdata = '0;
    e_ready = 1'b1;
    e_resp  = 1'b0;
    e_to1   = 1'b0;
    e_def1  = 1'b0;
    e_slv   = 1'b0;
    if (s == 0) begin
      e_ready = 1'b1;
    end else if (s >= 2 && s < 2 + N) begin
      e_slv   = 1'b1;
      e_rdata = rdata[(s-2)*W +: W];
      e_ready = ready[s-2];
      e_resp  = resp[s-2];
`ifdef AHB_MUX_TIMEOUT_EN
      if (m_to2) begin
        e_rdata = '0; e_ready = 1'b1; e_resp = 1'b1;
      end else if (m_wait == T - 1) begin
        e_rdata = '0; e_ready = 1'b0; e_resp = 1'b1; e_to1 = 1'b1;
      end
`endif
    end else begin
      if (m_def_err) begin
        e_resp = 1'b1;
      end else if (m_dp >= 2'd2) begin
        e_ready = 1'b0; e_resp = 1'b1; e_def1 = 1'b1;
      end
    end
    chk("hrdata", hrdata, e_rdata);
    chk("hready", W'(hready), W'(e_ready));
    chk("hresp", W'(hresp), W'(e_resp));
    chk("multi_ready", W'(mready), W'(e_ready));
    chk("timeout_flag", W'(flag), W'(m_flag));
  end

  // Model advance at each clock edge, using the response just predicted
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_dp = 2'd0; m_def_err = 1'b0; m_wait = 0; m_to2 = 1'b0; m_flag = 1'b0;
    end else begin
      if (e_ready) m_dp = htrans;
      m_def_err = e_def1;
      m_to2     = e_to1;
      if (e_to1) m_flag = 1'b1;
      m_wait = (e_slv && !e_ready && !e_to1) ? m_wait + 1 : 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_random();
    if (e_ready) begin
      sel    = 2'($urandom_range(0, 3));
      htrans = 2'($urandom_range(0, 3));
    end
    rdata = {$urandom, $urandom};
    for (int k = 0; k < N; k++) ready[k] = ($urandom_range(0, 9) < 7);
    resp = 2'($urandom_range(0, 3));
  endtask

  initial begin
    int n;
    sel = '0; htrans = 2'd0; rdata = '0; ready = '1; resp = '0;
    repeat (2) @(posedge clk);
    look();
    // Reset held, no selection
    chk("rst_hready", W'(hready), W'(1));
    chk("rst_hresp", W'(hresp), W'(0));
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_flag", W'(flag), W'(0));
    rstn = 1'b1;
    step();

    // Slave 0 zero-wait read
    sel = 2'd2; rdata[31:0] = 32'hA5A5_0001; ready = 2'b11; resp = 2'b00;
    look();
    chk("s0_hrdata", hrdata, 32'hA5A5_0001);
    chk("s0_multi_ready", W'(mready), W'(1));
    step();

    // Slave 1 inserts three wait states
    sel = 2'd3; ready = 2'b01; n = 0;
    repeat (3) begin
      look();
      if (hready == 1'b0) n++;
      step();
    end
    ready = 2'b11;
    look();
    chk("s1_wait_cycles", W'(n), W'(3));
    chk("s1_done_hready", W'(hready), W'(1));
    step();

    // NONSEQ to unmapped address followed by an IDLE transfer
    sel = 2'd0; htrans = 2'd2;
    step();
    sel = 2'd1; htrans = 2'd0;
    look(); chk("ds_c1_hready", W'(hready), W'(0)); chk("ds_c1_hresp", W'(hresp), W'(1));
    step();
    look(); chk("ds_c2_hready", W'(hready), W'(1)); chk("ds_c2_hresp", W'(hresp), W'(1));
    step();
    look(); chk("ds_idle_hready", W'(hready), W'(1)); chk("ds_idle_hresp", W'(hresp), W'(0));
    step();

    // Back-to-back NONSEQ to unmapped address
    sel = 2'd0; htrans = 2'd2;
    step();
    sel = 2'd1;
    look(); chk("b2b_err1a", {30'd0, hready, hresp}, 32'd1);
    step();
    look(); chk("b2b_err2a", {30'd0, hready, hresp}, 32'd3);
    step();
    htrans = 2'd0;
    look(); chk("b2b_err1b", {30'd0, hready, hresp}, 32'd1);
    step();
    look(); chk("b2b_err2b", {30'd0, hready, hresp}, 32'd3);
    step();
    look(); chk("b2b_okay", {30'd0, hready, hresp}, 32'd2);
    step();

    // Reset asserted during ERR1
    sel = 2'd0; htrans = 2'd2;
    step();
    sel = 2'd1; htrans = 2'd0;
    look(); chk("rst_err1", {30'd0, hready, hresp}, 32'd1);
    rstn = 1'b0;
    look();
    rstn = 1'b1;
    look(); chk("rst_no_err2", {30'd0, hready, hresp}, 32'd2);
    step();

    // Hung slave 0
    sel = 2'd0; htrans = 2'd2; ready = 2'b11; resp = 2'b00;
    step();
    sel = 2'd2; htrans = 2'd0; ready = 2'b10;
`ifdef AHB_MUX_TIMEOUT_EN
    n = 0;
    for (int i = 1; i < T; i++) begin
      look();
      if (hready !== 1'b0 || hresp !== 1'b0) n++;
      step();
    end
    chk("to_plain_waits", W'(n), W'(0));
    look(); chk("to_err1", {30'd0, hready, hresp}, 32'd1);
    step();
    look(); chk("to_err2", {30'd0, hready, hresp}, 32'd3);
    chk("to_flag_set", W'(flag), W'(1));
    step();
    sel = 2'd0; ready = 2'b11;
    look(); chk("to_flag_sticky", W'(flag), W'(1));
    step();
`else
    n = 0;
    repeat (T + 4) begin
      look();
      if (hready == 1'b0 && hresp == 1'b0) n++;
      step();
    end
    chk("hung_waits", W'(n), W'(T + 4));
    chk("hung_flag", W'(flag), W'(0));
    ready = 2'b11;
    look(); chk("hung_release", W'(hready), W'(1));
    step();
`endif

    // Randomized traffic checked by the compare process
    repeat (3000) begin
      drive_random();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ahb_slave_mux.md
# ahb_slave_mux

AHB-Lite slave-to-master response multiplexer sitting directly downstream of the address decoder. It consumes the decoder's data-phase select code, routes the selected slave's read data, ready and response to the master, and returns the ready signal the decoder uses to advance its address pipeline. It embeds the default slave that answers unmapped addresses with a two-cycle ERROR, and optionally includes a hung-slave timeout.

## Interface
Parameters:
- SLAVE_DEVICES, 2, number of real slaves; select code width is $clog2(SLAVE_DEVICES)+1.
- AHB_DATA_WIDTH, 32, HRDATA width.
- TIMEOUT_CYCLES, 16, wait-state limit before a forced ERROR (timeout build only); legal range 2..1023.

Ports:
- ahb_clk_in  in  1  AHB clock.
- ahb_rstn_in  in  1  asynchronous, active-low reset.
- multi_sel_in  in  $clog2(SLAVE_DEVICES)+1  data-phase select from decoder: 0 none, 1 default slave, k+2 slave k.
- htrans_in  in  2  master HTRANS, address phase.
- slave_rdata_in  in  SLAVE_DEVICES*AHB_DATA_WIDTH  packed HRDATA, slave k at bits [k*W +: W].
- slave_ready_in  in  SLAVE_DEVICES  HREADYOUT per slave.
- slave_resp_in  in  SLAVE_DEVICES  HRESP per slave.
- hrdata_out  out  AHB_DATA_WIDTH  read data to master.
- hready_out  out  1  HREADY to master and to every slave.
- hresp_out  out  1  HRESP to master.
- multi_ready_out  out  1  equal to hready_out; drives the decoder's multi_ready_in.
- timeout_flag_out  out  1  sticky timeout indicator.

## Operation
- htrans_dp register: captures htrans_in when hready_out=1, holds otherwise, so it is aligned with multi_sel_in (data phase).
- sel=0: hready_out=1, hresp_out=0, hrdata_out=0.
- sel=k+2, k<SLAVE_DEVICES: outputs = slave k's rdata/ready/resp. sel codes beyond range behave as sel=1.
- sel=1 (default slave), FSM DS_IDLE/DS_ERR1/DS_ERR2:
  - DS_IDLE: if htrans_dp is NONSEQ(2) or SEQ(3) -> DS_ERR1; outputs are the FSM outputs of the state being entered, i.e. ERR1 is visible in the first data-phase cycle. IDLE/BUSY -> zero-wait OKAY (hready 1, hresp 0).
  - DS_ERR1: hready 0, hresp 1 -> DS_ERR2.
  - DS_ERR2: hready 1, hresp 1 -> DS_IDLE; a NONSEQ/SEQ pipelined behind it re-enters DS_ERR1 next cycle.
  - Implemented as combinational ERR1 detection on entry plus registered ERR2 state; the default-slave hrdata is always 0.
- The FSM advances only while sel=1; otherwise it is forced to DS_IDLE.

## Timing
- Data path purely combinational from slave inputs to master outputs (zero added latency).
- Registered state: htrans_dp, the default-slave FSM, the timeout counter, and the flag.
- Reset values: htrans_dp=IDLE, FSM=DS_IDLE, counter=0, timeout_flag_out=0. With decoder reset (sel=0), hready_out=1, hresp_out=0, hrdata_out=0.
- Reset mid-ERROR returns to DS_IDLE immediately; no residual ERROR cycle.
- Default-slave ERROR is always exactly 2 cycles; OKAY to IDLE/BUSY is 0 wait states.

## Configuration
- AHB_MUX_TIMEOUT_EN defined:
  - A counter increments each cycle a real slave is selected with slave_ready_in=0, and clears on ready or sel change.
  - When the count reaches TIMEOUT_CYCLES-1, the mux overrides the slave with the two-cycle ERROR sequence (hready 0/hresp 1, then hready 1/hresp 1). The slave's outputs are ignored during these cycles.
  - timeout_flag_out sets and stays set until reset.
- Macro undefined: no counter; slave wait states are passed through unbounded; timeout_flag_out tied 0.

## Structure
- Shared package ahb_pkg holds the HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), the HRESP OKAY/ERROR encodings, and the select-code constants SEL_NONE=0, SEL_DEFAULT=1, SEL_SLAVE_BASE=2, shared with the decoder.
- Sub-module ahb_default_slave contains the htrans_dp consumer FSM and outputs hready/hresp; the mux instantiates it once.

## Test plan
- Reset held, sel=0 -> hready_out=1, hresp_out=0, hrdata_out=0, timeout_flag_out=0.
- sel=2, slave0 rdata=32'hA5A5_0001 ready=1 resp=0 -> hrdata_out=32'hA5A5_0001, multi_ready_out=1; sel=3 with slave1 ready=0 for 3 cycles -> hready_out low for exactly 3 cycles.
- NONSEQ to an unmapped address (sel=1 in the data phase) -> cycle1 hready=0/hresp=1, cycle2 hready=1/hresp=1, cycle3 OKAY; back-to-back NONSEQ to an unmapped address -> second ERR1 immediately after ERR2.
- IDLE transfer with sel=1 -> hready=1, hresp=0 in the same cycle, FSM stays DS_IDLE.
- Reset asserted during DS_ERR1 -> after release, hready_out=1 and hresp_out=0 with no ERR2 cycle.
- With AHB_MUX_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave0 ready held 0 -> forced ERROR begins at wait cycle 16 and timeout_flag_out=1 thereafter; without the macro, the wait persists and the flag stays 0.
